multi_alarm: RTL and testbench
==============================

MULTI_ALARM -- requirements
Module: multi_alarm

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm channels (range 2..8).
REQ-002 Parameter SNOOZE_MIN, default 5, snooze length in minutes (range 1..30).
REQ-003 Parameter RING_SEC, default 60, ring duration in seconds before auto-dismiss (range 1..255).
REQ-004 Port list, one per line:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset; asserted at 0.
- sec_tick  in  1  one-cycle pulse once per second.
- time_value  in  24  current time, BCD {hh, mm, ss}.
- btn  in  5  one-cycle pulses: [0] next channel, [1] next field, [2] increment, [3] enable toggle, [4] dismiss.
- btn_snooze  in  1  one-cycle snooze pulse.
- disp_ch  out  CH_W  selected channel; CH_W = max(1, $clog2(NUM_ALARMS)).
- disp_value  out  16  BCD {hh, mm} of the selected channel.
- cursor_pos  out  2  0 idle, 1 hour, 2 minute.
- enable_mask  out  NUM_ALARMS  per-channel enable.
- alarm  out  1  high while any channel is RINGING.
- ring_ch  out  CH_W  index of the ringing channel; 0 when alarm is low.

Function
REQ-005 Channel state: IDLE, PENDING, RINGING or SNOOZED; at most one channel SHALL be RINGING at any time.
REQ-006 Match condition: on sec_tick, channel enabled, channel hh:mm equals time_value[23:8], time_value[7:0] == 8'h00.
- A matching IDLE channel SHALL move to PENDING.
REQ-007 If no channel is RINGING, the lowest-index PENDING channel SHALL enter RINGING on the next cycle.
- The ring counter loads RING_SEC.
REQ-008 RINGING counter SHALL decrement on each sec_tick.
- At zero: channel returns to IDLE.
- Alarm deasserts within 1 cycle.
REQ-009 btn[4] while RINGING: ringing channel returns to IDLE.
- btn[4] while nothing is RINGING: all SNOOZED channels return to IDLE.
REQ-010 btn[0]: disp_ch increments, wrapping NUM_ALARMS-1 -> 0; cursor_pos is forced to 0.
REQ-011 btn[1] cycles cursor_pos 0 -> 1 -> 2 -> 0.
REQ-012 btn[2] with cursor 1: selected hour +1 in BCD, 23 -> 00; with cursor 2: minute +1, 59 -> 00; with cursor 0: ignored.
REQ-013 btn[3] toggles enable_mask[disp_ch].
- Disabling a channel SHALL return it to IDLE from any state in the same cycle.
REQ-014 Editing a RINGING, PENDING or SNOOZED channel's time SHALL NOT change its state.
REQ-015 Simultaneous btn[4] and btn_snooze: dismiss wins.
REQ-016 Simultaneous sec_tick and any button: both actions SHALL take effect in the same cycle.
REQ-017 Outputs SHALL be registered; a button effect is visible on the cycle after the pulse.

Reset
REQ-018 reset low SHALL asynchronously set:
- all channels IDLE with value 00:00;
- enable_mask 0, disp_ch 0, cursor_pos 0;
- alarm 0, ring_ch 0;
- all counters 0.
REQ-019 Reset asserted mid-ring SHALL drop alarm immediately, without waiting for a clock edge.
REQ-020 Leaving reset SHALL be synchronous to clk; the first match evaluation is on the first sec_tick after release.

Configuration
REQ-021 Macro MULTI_ALARM_SNOOZE_EN.
REQ-022 Defined:
- btn_snooze while RINGING moves the channel to SNOOZED and loads a per-channel counter with SNOOZE_MIN*60.
- The counter decrements on sec_tick; at zero the channel moves to PENDING.
REQ-023 Undefined:
- btn_snooze is ignored.
- The SNOOZED state and snooze counters are not synthesised.
- Behaviour is otherwise identical.

Verification
REQ-024 Reset scenario: after reset, outputs match REQ-018; six btn[0] pulses with NUM_ALARMS=4 -> disp_ch sequence 1,2,3,0,1,2.
REQ-025 Edit scenario: set channel 0 to 23:59 via btn[1]/btn[2], then one hour and one minute increment -> disp_value 16'h0000.
REQ-026 Ring scenario: channel 1 at 07:30 enabled; time 07:30:00 with sec_tick -> alarm=1, ring_ch=1; alarm drops 1 cycle after RING_SEC further ticks.
REQ-027 Collision scenario: channels 0 and 2 both at 06:00 -> ring_ch=0 first; btn[4] -> ring_ch=2 next cycle; second btn[4] -> alarm=0.
REQ-028 Snooze scenario (macro defined, SNOOZE_MIN=1): ringing channel, btn_snooze -> alarm=0; after 60 sec_ticks -> alarm=1, same ring_ch.
- Macro undefined: alarm stays 1 after btn_snooze.
REQ-029 Disable-while-ringing scenario: btn[3] on the ringing channel -> alarm=0 next cycle, enable bit cleared.

Source files
------------

// File: rtl/multi_alarm.sv
// multi_alarm: multi-channel BCD alarm with edit UI and single-ringer arbitration.
// Snooze support (SNOOZED state, per-channel counters) is built only with MULTI_ALARM_SNOOZE_EN.
module multi_alarm #(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC = 60,
  localparam int CH_W = ($clog2(NUM_ALARMS) < 1) ? 1 : $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_tick,
  input  logic [23:0]           time_value,
  input  logic [4:0]            btn,
  input  logic                  btn_snooze,
  output logic [CH_W-1:0]       disp_ch,
  output logic [15:0]           disp_value,
  output logic [1:0]            cursor_pos,
  output logic [NUM_ALARMS-1:0] enable_mask,
  output logic                  alarm,
  output logic [CH_W-1:0]       ring_ch
);
  typedef enum logic [1:0] {IDLE, PENDING, RINGING, SNOOZED} st_t;
  st_t st [NUM_ALARMS];
  st_t st_n [NUM_ALARMS];
  logic [7:0] hh [NUM_ALARMS];
  logic [7:0] hh_n [NUM_ALARMS];
  logic [7:0] mm [NUM_ALARMS];
  logic [7:0] mm_n [NUM_ALARMS];
  logic [7:0] ring_cnt, ring_cnt_n;
  logic [CH_W-1:0] ch_n, ring_ch_n, promo_ch;
  logic [1:0] cur_n;
  logic [NUM_ALARMS-1:0] en_n;
  logic [15:0] dv_n;
  logic any_ring, promo, alarm_n;
`ifdef MULTI_ALARM_SNOOZE_EN
  logic [10:0] snz [NUM_ALARMS];
  logic [10:0] snz_n [NUM_ALARMS];
`else
  logic unused_snooze;
  assign unused_snooze = btn_snooze;
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v == lim) ? 8'h00 : (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
  endfunction

  always_comb begin
    any_ring = 1'b0;
    promo = 1'b0;
    promo_ch = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (st[i] == RINGING) any_ring = 1'b1;
      if (st[i] == PENDING) begin
        promo = 1'b1;
        promo_ch = CH_W'(i);
      end
    end
    promo = promo & ~any_ring;
    ch_n = btn[0] ? ((disp_ch == CH_W'(NUM_ALARMS - 1)) ? '0 : disp_ch + 1'b1) : disp_ch;
    cur_n = btn[0] ? 2'd0 : btn[1] ? ((cursor_pos == 2'd2) ? 2'd0 : cursor_pos + 2'd1) : cursor_pos;
    en_n = enable_mask ^ (btn[3] ? NUM_ALARMS'(1) << disp_ch : '0);
    ring_cnt_n = ring_cnt;
    alarm_n = 1'b0;
    ring_ch_n = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      hh_n[i] = hh[i];
      mm_n[i] = mm[i];
      st_n[i] = st[i];
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_n[i] = snz[i];
`endif
      if (btn[2] && disp_ch == CH_W'(i) && cursor_pos == 2'd1) hh_n[i] = bcd_inc(hh[i], 8'h23);
      if (btn[2] && disp_ch == CH_W'(i) && cursor_pos == 2'd2) mm_n[i] = bcd_inc(mm[i], 8'h59);
      case (st[i])
        IDLE: st_n[i] = (sec_tick && enable_mask[i] && {hh[i], mm[i]} == time_value[23:8] &&
                         time_value[7:0] == 8'h00) ? PENDING : IDLE;
        PENDING: if (promo && promo_ch == CH_W'(i)) begin
          st_n[i] = RINGING;
          ring_cnt_n = 8'(RING_SEC);
        end
        RINGING: if (btn[4]) st_n[i] = IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
        else if (btn_snooze) begin
          st_n[i] = SNOOZED;
          snz_n[i] = 11'(SNOOZE_MIN * 60);
        end
`endif
        else if (sec_tick) begin
          if (ring_cnt <= 8'd1) st_n[i] = IDLE;
          else ring_cnt_n = ring_cnt - 8'd1;
        end
`ifdef MULTI_ALARM_SNOOZE_EN
        SNOOZED: if (btn[4] && !any_ring) st_n[i] = IDLE;
        else if (sec_tick) begin
          if (snz[i] <= 11'd1) st_n[i] = PENDING;
          else snz_n[i] = snz[i] - 11'd1;
        end
`endif
        default: st_n[i] = IDLE;
      endcase
      // disabling overrides every other transition this cycle
      if (btn[3] && disp_ch == CH_W'(i) && enable_mask[i]) st_n[i] = IDLE;
      if (st_n[i] == RINGING) begin
        alarm_n = 1'b1;
        ring_ch_n = CH_W'(i);
      end
    end
    dv_n = {hh_n[ch_n], mm_n[ch_n]};
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st[i] <= IDLE;
        hh[i] <= '0;
        mm[i] <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz[i] <= '0;
`endif
      end
      ring_cnt <= '0;
      disp_ch <= '0;
      disp_value <= '0;
      cursor_pos <= '0;
      enable_mask <= '0;
      alarm <= 1'b0;
      ring_ch <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st[i] <= st_n[i];
        hh[i] <= hh_n[i];
        mm[i] <= mm_n[i];
`ifdef MULTI_ALARM_SNOOZE_EN
        snz[i] <= snz_n[i];
`endif
      end
      ring_cnt <= ring_cnt_n;
      disp_ch <= ch_n;
      disp_value <= dv_n;
      cursor_pos <= cur_n;
      enable_mask <= en_n;
      alarm <= alarm_n;
      ring_ch <= ring_ch_n;
    end
endmodule

// File: tb/tb_multi_alarm.sv
// tb_multi_alarm: directed scenarios plus random stimulus against an event-level alarm model.
module tb_multi_alarm;
  localparam int N = 4;
  localparam int SM = 1;
  localparam int RS = 8;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif
  localparam int ID = 0, PD = 1, RG = 2, SZ = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sec_tick = 1'b0;
  logic [23:0] time_value = '0;
  logic [4:0] btn = '0;
  logic btn_snooze = 1'b0;
  logic [1:0] disp_ch, cursor_pos, ring_ch;
  logic [15:0] disp_value;
  logic [N-1:0] enable_mask;
  logic alarm;
  int total = 0, bad = 0;

  int m_h [N], m_m [N], m_st [N], m_snz [N];
  int m_left, m_ch, m_cur;
  bit [N-1:0] m_en;

  multi_alarm #(.NUM_ALARMS(N), .SNOOZE_MIN(SM), .RING_SEC(RS)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .time_value(time_value), .btn(btn),
    .btn_snooze(btn_snooze), .disp_ch(disp_ch), .disp_value(disp_value), .cursor_pos(cursor_pos),
    .enable_mask(enable_mask), .alarm(alarm), .ring_ch(ring_ch));

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_h[i] = 0; m_m[i] = 0; m_st[i] = ID; m_snz[i] = 0;
    end
    m_left = 0; m_ch = 0; m_cur = 0; m_en = '0;
  endtask

  task automatic model_apply(input logic [4:0] b, input logic s, input logic t, input logic [23:0] tv);
    bit had_ring;
    int oc, ocur;
    had_ring = 0; oc = m_ch; ocur = m_cur;
    for (int i = 0; i < N; i++) if (m_st[i] == RG) had_ring = 1;
    if (t) for (int i = 0; i < N; i++) begin
      if (m_st[i] == ID && m_en[i] && tv == {bcd(m_h[i]), bcd(m_m[i]), 8'h00}) m_st[i] = PD;
      else if (m_st[i] == RG && !b[4] && !(SNZ_EN && s)) begin
        m_left--;
        if (m_left == 0) m_st[i] = ID;
      end else if (m_st[i] == SZ) begin
        m_snz[i]--;
        if (m_snz[i] == 0) m_st[i] = PD;
      end
    end
    if (b[4]) begin
      for (int i = 0; i < N; i++) if (had_ring ? m_st[i] == RG : m_st[i] == SZ) m_st[i] = ID;
    end else if (s && SNZ_EN) begin
      for (int i = 0; i < N; i++) if (m_st[i] == RG) begin m_st[i] = SZ; m_snz[i] = SM * 60; end
    end
    if (b[2] && ocur == 1) m_h[oc] = (m_h[oc] + 1) % 24;
    if (b[2] && ocur == 2) m_m[oc] = (m_m[oc] + 1) % 60;
    if (b[0]) begin m_ch = (m_ch + 1) % N; m_cur = 0; end
    else if (b[1]) m_cur = (m_cur + 1) % 3;
    if (b[3]) begin
      m_en[oc] = !m_en[oc];
      if (!m_en[oc]) m_st[oc] = ID;
    end
  endtask

  task automatic model_settle();
    bit busy;
    busy = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == RG) busy = 1;
    for (int i = 0; i < N && !busy; i++) if (m_st[i] == PD) begin
      m_st[i] = RG; m_left = RS; busy = 1;
    end
  endtask

  task automatic check_all(input string ph);
    bit ring;
    int rc;
    ring = 0; rc = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == RG) begin ring = 1; rc = i; end
    chk({ph, "_disp_ch"}, 32'(disp_ch), 32'(m_ch));
    chk({ph, "_disp_value"}, 32'(disp_value), 32'({bcd(m_h[m_ch]), bcd(m_m[m_ch])}));
    chk({ph, "_cursor"}, 32'(cursor_pos), 32'(m_cur));
    chk({ph, "_enable"}, 32'(enable_mask), 32'(m_en));
    chk({ph, "_alarm"}, 32'(alarm), 32'(ring));
    chk({ph, "_ring_ch"}, 32'(ring_ch), 32'(rc));
  endtask

  task automatic step(input logic [4:0] b, input logic s, input logic t, input logic [23:0] tv);
    @(negedge clk);
    btn = b; btn_snooze = s; sec_tick = t; time_value = tv;
    model_apply(b, s, t, tv);
    @(negedge clk);
    btn = '0; btn_snooze = 1'b0; sec_tick = 1'b0;
    check_all("imm");
    model_settle();
    @(negedge clk);
    check_all("set");
  endtask

  task automatic press(input int k);
    step(5'(1 << k), 1'b0, 1'b0, 24'h000001);
  endtask

  task automatic goto_ch(input int c);
    while (m_ch != c) press(0);
  endtask

  task automatic set_cur(input int c);
    while (m_cur != c) press(1);
  endtask

  task automatic tick(input logic [23:0] tv);
    step(5'd0, 1'b0, 1'b1, tv);
  endtask

  logic [4:0] rb;
  logic rt, rs;
  logic [23:0] rtv;
  int r, c;
  int seq [6] = '{1, 2, 3, 0, 1, 2};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_ring_ch", 32'(ring_ch), 0);
    chk("rst_enable", 32'(enable_mask), 0);
    chk("rst_disp", 32'({disp_ch, cursor_pos, disp_value}), 0);
    reset = 1'b1;
    @(negedge clk);
    check_all("rel");
    for (int i = 0; i < 6; i++) begin
      press(0);
      chk("nav_seq", 32'(disp_ch), 32'(seq[i]));
    end
    goto_ch(0);
    set_cur(1);
    repeat (23) press(2);
    set_cur(2);
    repeat (59) press(2);
    chk("edit_2359", 32'(disp_value), 32'h2359);
    press(2);
    set_cur(1);
    press(2);
    chk("edit_wrap", 32'(disp_value), 32'h0000);
    goto_ch(1);
    set_cur(1);
    repeat (7) press(2);
    set_cur(2);
    repeat (30) press(2);
    press(3);
    tick(24'h073000);
    chk("ring_on", 32'(alarm), 1);
    chk("ring_ch1", 32'(ring_ch), 1);
    repeat (RS - 1) tick(24'h073001);
    chk("ring_hold", 32'(alarm), 1);
    tick(24'h073001);
    chk("ring_off", 32'(alarm), 0);
    goto_ch(0);
    set_cur(1);
    repeat (6) press(2);
    press(3);
    goto_ch(2);
    set_cur(1);
    repeat (6) press(2);
    press(3);
    tick(24'h060000);
    chk("coll_first", 32'(ring_ch), 0);
    press(4);
    chk("coll_second", 32'(ring_ch), 2);
    press(4);
    chk("coll_done", 32'(alarm), 0);
    tick(24'h073000);
    step(5'd0, 1'b1, 1'b0, 24'h073001);
    chk("snz_alarm", 32'(alarm), SNZ_EN ? 0 : 1);
    repeat (60) tick(24'h073001);
    chk("snz_back", 32'(alarm), SNZ_EN ? 1 : 0);
    press(4);
    goto_ch(1);
    tick(24'h073000);
    press(3);
    chk("dis_alarm", 32'(alarm), 0);
    chk("dis_en", 32'(enable_mask[1]), 0);
    tick(24'h060000);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_alarm", 32'(alarm), 0);
    chk("async_state", 32'({ring_ch, disp_ch, enable_mask}), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 9);
      rb = '0; rs = 1'b0; rt = 1'b0;
      if (r <= 3) begin
        rb = 5'(1 << $urandom_range(0, 3));
        rt = 1'($urandom_range(0, 1));
      end else if (r <= 7) rt = 1'b1;
      else if (r == 8) rb = 5'b10000;
      else rs = 1'b1;
      c = $urandom_range(0, N - 1);
      rtv = ($urandom_range(0, 2) != 0) ? {bcd(m_h[c]), bcd(m_m[c]), 8'h00} :
            {bcd($urandom_range(0, 23)), bcd($urandom_range(0, 59)), bcd($urandom_range(0, 59))};
      step(rb, rs, rt, rtv);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
